// File: rtl/nonce_search_ctrl_if.sv
// nonce_search_ctrl_if
//   Handshake bundle between the nonce search controller and one sha256_core.
//   master : controller side (drives header/start, receives done/digest)
//   slave  : hash core side (receives header/start, drives done/digest)
// Signals
//   core_header  640  {header_base, bswap32(nonce)} presented to the core
//   core_start   1    1-cycle launch pulse
//   core_done    1    1-cycle completion pulse, core_digest valid with it
//   core_digest  256  double-SHA256 result, big-endian word order
interface nonce_search_ctrl_if;
   logic [639:0] core_header;
   logic         core_start;
   logic         core_done;
   logic [255:0] core_digest;

   modport master (
      output core_header,
      output core_start,
      input  core_done,
      input  core_digest
   );

   modport slave (
      input  core_header,
      input  core_start,
      output core_done,
      output core_digest
   );
endinterface

// File: rtl/nonce_search_ctrl.sv
// nonce_search_ctrl
//   Drives sha256_core with one header per nonce and checks each returned
//   digest against a 256-bit target. Reports the winning nonce, range
//   exhaustion, or a core timeout.
// Parameters
//   NONCE_STRIDE    nonce increment per attempt (>= 1)
//   TIMEOUT_CYCLES  cycles allowed in WAIT before core_err is raised
// Optional build macro
//   HASH_COUNT_EN   adds hash_count[47:0], a saturating count of CHECK cycles
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               1-cycle pulse; accepted only in IDLE
//   abort               level; forces IDLE, highest priority
//   header_base         header bytes 0..75, big-endian bit order
//   target              hit when byte-reversed digest <= target
//   nonce_first/last    inclusive search range
//   core                master side of the hash core handshake
//   busy                high while ISSUE/WAIT/CHECK
//   found/exhausted/core_err  sticky result flags, cleared on accepted start
//   found_nonce         winning nonce, native byte order
//   found_digest        winning digest exactly as received
module nonce_search_ctrl #(
   parameter int unsigned NONCE_STRIDE   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [607:0]        header_base,
   input  logic [255:0]        target,
   input  logic [31:0]         nonce_first,
   input  logic [31:0]         nonce_last,
   nonce_search_ctrl_if.master core,
   output logic                busy,
   output logic                found,
   output logic                exhausted,
   output logic                core_err,
   output logic [31:0]         found_nonce,
   output logic [255:0]        found_digest
`ifdef HASH_COUNT_EN
   ,
   output logic [47:0]         hash_count
`endif
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FOUND, EXHAUST} state_t;

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   function automatic logic [31:0] bswap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [255:0] bswap256(input logic [255:0] d);
      logic [255:0] r;
      for (int i = 0; i < 32; i++) begin
         r[8*i +: 8] = d[255 - 8*i -: 8];
      end
      return r;
   endfunction

`ifdef HASH_COUNT_EN
   function automatic logic [47:0] sat_inc48(input logic [47:0] v);
      return (&v) ? v : v + 48'd1;
   endfunction
`endif

   state_t           state, state_nxt;
   logic [31:0]      nonce;
   logic [CNT_W-1:0] wait_cnt;
   logic [255:0]     target_q;
   logic [31:0]      last_q;
   logic [255:0]     digest_q;
   logic [32:0]      nonce_sum;
   logic             hit;
   logic             accept, retry, capture;
   logic             set_found, set_exh, set_err;
   logic             core_start_r;
   logic [639:0]     core_header_r;

   // 33-bit sum so that stepping past 0xFFFFFFFF ends the search instead of wrapping.
   assign nonce_sum = {1'b0, nonce} + 33'(NONCE_STRIDE);
   assign hit       = (bswap256(digest_q) <= target_q);

   assign core.core_start  = core_start_r;
   assign core.core_header = core_header_r;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      retry     = 1'b0;
      capture   = 1'b0;
      set_found = 1'b0;
      set_exh   = 1'b0;
      set_err   = 1'b0;
      if (abort) begin
         // abort overrides every transition, including a hit or a done in the same cycle
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  accept    = 1'b1;
                  state_nxt = ISSUE;
               end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
               if (core.core_done) begin
                  capture   = 1'b1;
                  state_nxt = CHECK;
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  set_err   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            CHECK: begin
               if (hit) begin
                  set_found = 1'b1;
                  state_nxt = FOUND;
               end else if (nonce_sum[32] || (nonce_sum[31:0] > last_q)) begin
                  set_exh   = 1'b1;
                  state_nxt = EXHAUST;
               end else begin
                  retry     = 1'b1;
                  state_nxt = ISSUE;
               end
            end
            FOUND, EXHAUST: begin
               if (start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Control and output registers; core_start/core_header are loaded on entry to ISSUE
   // so the launch pulse is a clean registered single cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         nonce         <= '0;
         wait_cnt      <= '0;
         core_start_r  <= 1'b0;
         core_header_r <= '0;
         busy          <= 1'b0;
         found         <= 1'b0;
         exhausted     <= 1'b0;
         core_err      <= 1'b0;
         found_nonce   <= '0;
         found_digest  <= '0;
      end else begin
         state        <= state_nxt;
         core_start_r <= accept | retry;
         busy         <= (state_nxt == ISSUE) || (state_nxt == WAIT) || (state_nxt == CHECK);
         if (state == ISSUE) begin
            wait_cnt <= '0;
         end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (accept) begin
            nonce         <= nonce_first;
            core_header_r <= {header_base, bswap32(nonce_first)};
            found         <= 1'b0;
            exhausted     <= 1'b0;
            core_err      <= 1'b0;
         end else if (retry) begin
            // upper 608 bits already hold the latched header base
            nonce         <= nonce_sum[31:0];
            core_header_r <= {core_header_r[639:32], bswap32(nonce_sum[31:0])};
         end
         if (set_found) begin
            found        <= 1'b1;
            found_nonce  <= nonce;
            found_digest <= digest_q;
         end
         if (set_exh) exhausted <= 1'b1;
         if (set_err) core_err  <= 1'b1;
      end
   end

   // Search operands and the captured digest need no reset; they are only read after being loaded.
   always_ff @(posedge clk) begin
      if (accept) begin
         target_q <= target;
         last_q   <= nonce_last;
      end
      if (capture) digest_q <= core.core_digest;
   end

`ifdef HASH_COUNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hash_count <= '0;
      end else if (accept) begin
         hash_count <= '0;
      end else if (state == CHECK) begin
         hash_count <= sat_inc48(hash_count);
      end
   end
`endif

endmodule
